// File: rtl/hier_cfg_sequencer_if.sv
// Config-write request bus and register outputs of hier_cfg_sequencer.
// Requesters sit on the master side and the sequencer sits on the slave side.
interface hier_cfg_sequencer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_depth;
  logic [WIDTH*NREQ-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      o2;
  logic [WIDTH-1:0]      o3;
  logic [WIDTH-1:0]      o4;
  logic                  busy;
  logic                  err;

  modport master (
    output req_valid, req_depth, req_data,
    input  req_ready, o2, o3, o4, busy, err
  );

  modport slave (
    input  req_valid, req_depth, req_data,
    output req_ready, o2, o3, o4, busy, err
  );
endinterface

// File: rtl/hier_cfg_sequencer.sv
// Per-level config registers (levels 2/3/4) with round-robin write arbitration.
// An accepted write spends one cycle per level in WALK, then commits at its target level.
module hier_cfg_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEF2  = 20,
  parameter int unsigned DEF3  = 30,
  parameter int unsigned DEF4  = 40,
  parameter int unsigned NREQ  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hier_cfg_sequencer_if.slave  bus
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PTR_W-1:0] r_rr, w_rr_nxt;
  logic [1:0]       r_depth, w_depth_nxt;
  logic [1:0]       r_hop, w_hop_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic [WIDTH-1:0] r_o2, w_o2_nxt;
  logic [WIDTH-1:0] r_o3, w_o3_nxt;
  logic [WIDTH-1:0] r_o4, w_o4_nxt;
  logic             r_busy, r_err, w_err_nxt;
  logic [NREQ-1:0]  w_ready;
  logic [PTR_W-1:0] w_grant;
  logic             w_grant_vld;
  int unsigned      w_idx;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = 32'(r_rr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_grant_vld && bus.req_valid[PTR_W'(w_idx)]) begin
        w_grant_vld = 1'b1;
        w_grant     = PTR_W'(w_idx);
      end
    end
  end

  // Next-state, accept and commit logic.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_depth_nxt = r_depth;
    w_hop_nxt   = r_hop;
    w_data_nxt  = r_data;
    w_o2_nxt    = r_o2;
    w_o3_nxt    = r_o3;
    w_o4_nxt    = r_o4;
    w_err_nxt   = 1'b0;
    w_ready     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) begin
          w_ready[w_grant] = 1'b1;
          w_depth_nxt      = bus.req_depth[32'(w_grant) * 2 +: 2];
          w_data_nxt       = bus.req_data[32'(w_grant) * WIDTH +: WIDTH];
          w_hop_nxt        = 2'd1;
          w_rr_nxt         = (32'(w_grant) == NREQ - 1) ? '0 : w_grant + PTR_W'(1);
          if (w_depth_nxt == 2'd0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_WALK;
          end
        end
      end
      ST_WALK: begin
        if (r_hop == r_depth) begin
          w_state_nxt = ST_COMMIT;
        end else begin
          w_hop_nxt = r_hop + 2'd1;
        end
      end
      ST_COMMIT: begin
        case (r_depth)
          2'd1:    w_o2_nxt = r_data;
          2'd2:    w_o3_nxt = r_data;
          2'd3:    w_o4_nxt = r_data;
          default: ;
        endcase
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reset abandons any in-flight walk; nothing is committed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rr    <= '0;
      r_depth <= '0;
      r_hop   <= '0;
      r_data  <= '0;
      r_o2    <= WIDTH'(DEF2);
      r_o3    <= WIDTH'(DEF3);
      r_o4    <= WIDTH'(DEF4);
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_depth <= w_depth_nxt;
      r_hop   <= w_hop_nxt;
      r_data  <= w_data_nxt;
      r_o2    <= w_o2_nxt;
      r_o3    <= w_o3_nxt;
      r_o4    <= w_o4_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_err   <= w_err_nxt;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.o2        = r_o2;
  assign bus.o3        = r_o3;
  assign bus.o4        = r_o4;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_hier_cfg_sequencer.sv
// Bench for hier_cfg_sequencer: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model built from the latency rules.
module tb_hier_cfg_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREQ  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hier_cfg_sequencer_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  hier_cfg_sequencer #(
    .WIDTH(WIDTH), .DEF2(20), .DEF3(30), .DEF4(40), .NREQ(NREQ)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: register file, rr pointer, and edge numbers derived from the latency rules.
  logic [31:0] m_reg [1:3];
  int          m_rr, m_free, m_err_edge, m_commit_edge, m_commit_depth;
  logic [31:0] m_commit_data;
  bit          m_known = 1'b0;
  int          cyc = 0;

  // Requesters hold valid/depth/data until the model says they were accepted.
  bit          rq_valid [NREQ];
  int          rq_depth [NREQ];
  logic [31:0] rq_data  [NREQ];

  task automatic model_reset();
    m_reg[1]      = 32'd20;
    m_reg[2]      = 32'd30;
    m_reg[3]      = 32'd40;
    m_rr          = 0;
    m_free        = cyc + 1;
    m_err_edge    = -1;
    m_commit_edge = -1;
  endtask

  function automatic bit any_valid();
    for (int i = 0; i < NREQ; i++) if (rq_valid[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic raise(input int i, input int d, input logic [31:0] v);
    rq_valid[i] = 1'b1;
    rq_depth[i] = d;
    rq_data[i]  = v;
  endtask

  task automatic step(input bit rst_val);
    int g;
    logic [NREQ-1:0] exp_ready;
    @(negedge clk);
    rst_n = rst_val;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]             = rq_valid[i];
      bus.req_depth[2*i +: 2]      = 2'(rq_depth[i]);
      bus.req_data[i*WIDTH +: WIDTH] = rq_data[i];
    end
    #1;
    g = -1;
    exp_ready = '0;
    if (m_known && (cyc + 1 >= m_free)) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_rr + k) % NREQ;
        if (g < 0 && rq_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    if (m_known) check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    @(posedge clk);
    cyc++;
    if (!rst_val) begin
      m_known = 1'b1;
      model_reset();
    end else if (m_known) begin
      if (cyc == m_commit_edge) m_reg[m_commit_depth] = m_commit_data;
      if (g >= 0) begin
        if (rq_depth[g] == 0) begin
          m_err_edge = cyc;
          m_free     = cyc + 1;
        end else begin
          m_commit_edge  = cyc + rq_depth[g] + 1;
          m_commit_depth = rq_depth[g];
          m_commit_data  = rq_data[g];
          m_free         = cyc + rq_depth[g] + 2;
        end
        m_rr        = (g + 1) % NREQ;
        rq_valid[g] = 1'b0;
      end
    end
    #1;
    if (m_known) begin
      check_eq("o2", bus.o2, m_reg[1]);
      check_eq("o3", bus.o3, m_reg[2]);
      check_eq("o4", bus.o4, m_reg[3]);
      check_eq("busy", 32'(bus.busy), 32'(cyc + 2 <= m_free));
      check_eq("err", 32'(bus.err), 32'(cyc == m_err_edge));
    end
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((any_valid() || (cyc + 1 < m_free)) && n < max) begin
      step(1'b1);
      n++;
    end
    check_eq("drain_bound", 32'(n < max), 32'd1);
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_depth = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rq_valid[i] = 1'b0;
      rq_depth[i] = 0;
      rq_data[i]  = '0;
    end

    // Reset values, idle with no requests.
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check_eq("rst_o2", bus.o2, 32'd20);
    check_eq("rst_o3", bus.o3, 32'd30);
    check_eq("rst_o4", bus.o4, 32'd40);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);

    // Single level-2 write.
    raise(0, 1, 32'd8);
    drain(20);
    check_eq("d1_o2", bus.o2, 32'd8);

    // Deep then mid writes from the same requester.
    raise(0, 3, 32'd400);
    drain(20);
    raise(0, 2, 32'd80);
    drain(20);
    check_eq("seq_o2", bus.o2, 32'd8);
    check_eq("seq_o3", bus.o3, 32'd80);
    check_eq("seq_o4", bus.o4, 32'd400);

    // Contention from reset: req0 then req1.
    raise(0, 1, 32'd5);
    raise(1, 1, 32'd6);
    step(1'b0);
    drain(30);
    check_eq("rr0_o2", bus.o2, 32'd6);

    // After a lone req0 grant the pointer favours req1.
    raise(0, 1, 32'd1);
    drain(20);
    raise(0, 1, 32'd5);
    raise(1, 1, 32'd6);
    drain(30);
    check_eq("rr1_o2", bus.o2, 32'd5);

    // Illegal depth: err pulse, next requester served immediately after.
    raise(1, 0, 32'd99);
    raise(2, 1, 32'd3);
    drain(30);
    check_eq("err_o2", bus.o2, 32'd3);
    check_eq("err_o3", bus.o3, 32'd30);

    // Reset during WALK abandons the write.
    raise(0, 3, 32'd7);
    n = 0;
    while (rq_valid[0] && n < 20) begin
      step(1'b1);
      n++;
    end
    check_eq("walk_accept_bound", 32'(n < 20), 32'd1);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    for (int i = 0; i < 6; i++) step(1'b1);
    check_eq("abort_o4", bus.o4, 32'd40);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rq_valid[i] && $urandom_range(0, 3) == 0)
          raise(i, int'($urandom_range(0, 3)), $urandom);
      end
      step($urandom_range(0, 149) != 0);
    end
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
